// File: rtl/valu_pkg.sv
// Shared op-code encoding and FSM state type for the vector ALU unit.
package valu_pkg;

    // Element-wise op codes (same numbering as the scalar VALU).
    localparam logic [4:0] OpAdd    = 5'd0;
    localparam logic [4:0] OpSub    = 5'd1;
    localparam logic [4:0] OpRsub   = 5'd2;
    localparam logic [4:0] OpAnd    = 5'd3;
    localparam logic [4:0] OpOr     = 5'd4;
    localparam logic [4:0] OpXor    = 5'd5;
    localparam logic [4:0] OpSll    = 5'd6;
    localparam logic [4:0] OpSrl    = 5'd7;
    localparam logic [4:0] OpSra    = 5'd8;
    localparam logic [4:0] OpSeq    = 5'd9;
    localparam logic [4:0] OpSne    = 5'd10;
    localparam logic [4:0] OpSltu   = 5'd11;
    localparam logic [4:0] OpSlt    = 5'd12;
    localparam logic [4:0] OpSleu   = 5'd13;
    localparam logic [4:0] OpSle    = 5'd14;
    localparam logic [4:0] OpSgtu   = 5'd15;
    localparam logic [4:0] OpSgt    = 5'd16;
    localparam logic [4:0] OpMinu   = 5'd17;
    localparam logic [4:0] OpMin    = 5'd18;
    localparam logic [4:0] OpMaxu   = 5'd19;
    localparam logic [4:0] OpMax    = 5'd20;
    // Whole-vector ops handled in the top rather than in the lanes.
    localparam logic [4:0] OpMerge  = 5'd21;
    localparam logic [4:0] OpRedsum = 5'd22;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/valu_lane.sv
// One combinational ALU lane: computes a single element result from a/b.
module valu_lane
    import valu_pkg::*;
#(
    parameter int unsigned ELEN = 32
) (
    input  logic [ELEN-1:0] a_i,
    input  logic [4:0]      op_i,
    input  logic [ELEN-1:0] b_i,
    output logic [ELEN-1:0] result_o
);

    localparam int unsigned ShW = $clog2(ELEN);

    logic [ShW-1:0] sh;
    logic           eq;
    logic           ltu;
    logic           lts;

    assign sh  = b_i[ShW-1:0];
    assign eq  = (a_i == b_i);
    assign ltu = (a_i < b_i);
    assign lts = ($signed(a_i) < $signed(b_i));

    // Decode op; compare results are zero-extended flags, unknown ops give 0.
    always_comb begin
        result_o = '0;
        case (op_i)
            OpAdd:  result_o = a_i + b_i;
            OpSub:  result_o = a_i - b_i;
            OpRsub: result_o = b_i - a_i;
            OpAnd:  result_o = a_i & b_i;
            OpOr:   result_o = a_i | b_i;
            OpXor:  result_o = a_i ^ b_i;
            OpSll:  result_o = a_i << sh;
            OpSrl:  result_o = a_i >> sh;
            OpSra:  result_o = $unsigned($signed(a_i) >>> sh);
            OpSeq:  result_o = {{(ELEN-1){1'b0}}, eq};
            OpSne:  result_o = {{(ELEN-1){1'b0}}, ~eq};
            OpSltu: result_o = {{(ELEN-1){1'b0}}, ltu};
            OpSlt:  result_o = {{(ELEN-1){1'b0}}, lts};
            OpSleu: result_o = {{(ELEN-1){1'b0}}, ltu | eq};
            OpSle:  result_o = {{(ELEN-1){1'b0}}, lts | eq};
            OpSgtu: result_o = {{(ELEN-1){1'b0}}, ~(ltu | eq)};
            OpSgt:  result_o = {{(ELEN-1){1'b0}}, ~(lts | eq)};
            OpMinu: result_o = ltu ? a_i : b_i;
            OpMin:  result_o = lts ? a_i : b_i;
            OpMaxu: result_o = ltu ? b_i : a_i;
            OpMax:  result_o = lts ? b_i : a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/valu_vec_seq.sv
// Multi-cycle vector ALU: LANES elements per cycle, masking, tail-undisturbed
// writeback, merge and sequential sum reduction.
module valu_vec_seq
    import valu_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned ELEN  = 32,
    parameter int unsigned VLMAX = 32,
    parameter int unsigned VL_W  = $clog2(VLMAX + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4:0]            op_i,
    input  logic                  vm_i,
    input  logic [VL_W-1:0]       vl_i,
    input  logic [VLMAX*ELEN-1:0] vs1_i,
    input  logic [VLMAX*ELEN-1:0] vs2_i,
    input  logic [VLMAX*ELEN-1:0] vd_old_i,
    input  logic [VLMAX-1:0]      vmask_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [VLMAX*ELEN-1:0] vd_o
);

    localparam int unsigned NumSlices = VLMAX / LANES;

    state_e                state_q, state_d;
    logic [VL_W-1:0]       idx_q, idx_d;
    logic [VL_W-1:0]       vl_q, vl_d;
    logic [4:0]            op_q, op_d;
    logic                  vm_q, vm_d;
    logic [VLMAX*ELEN-1:0] vs1_q, vs1_d;
    logic [VLMAX*ELEN-1:0] vs2_q, vs2_d;
    logic [VLMAX*ELEN-1:0] vd_q, vd_d;
    logic [VLMAX-1:0]      vmask_q, vmask_d;
    logic [ELEN-1:0]       acc_q, acc_d;

    logic [VL_W-1:0]       vl_clamped;
    logic [ELEN-1:0]       lane_a   [LANES];
    logic [ELEN-1:0]       lane_b   [LANES];
    logic [ELEN-1:0]       lane_res [LANES];
    logic                  act;

    assign vl_clamped  = (vl_i > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl_i;
    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign vd_o        = vd_q;

    // Route the current slice's operands to the lanes (slice chosen by idx).
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = '0;
            lane_b[l] = '0;
            for (int s = 0; s < NumSlices; s++) begin
                if (idx_q == VL_W'(s * LANES)) begin
                    lane_a[l] = vs1_q[(s*LANES+l)*ELEN +: ELEN];
                    lane_b[l] = vs2_q[(s*LANES+l)*ELEN +: ELEN];
                end
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        valu_lane #(
            .ELEN(ELEN)
        ) u_lane (
            .a_i     (lane_a[g]),
            .op_i    (op_q),
            .b_i     (lane_b[g]),
            .result_o(lane_res[g])
        );
    end

    // Next-state: accept/latch in IDLE, per-slice writeback in EXEC, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vl_d    = vl_q;
        op_d    = op_q;
        vm_d    = vm_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        vd_d    = vd_q;
        vmask_d = vmask_q;
        acc_d   = acc_q;
        act     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    vl_d    = vl_clamped;
                    op_d    = op_i;
                    vm_d    = vm_i;
                    vs1_d   = vs1_i;
                    vs2_d   = vs2_i;
                    vmask_d = vmask_i;
                    vd_d    = vd_old_i;
                    acc_d   = vs1_i[ELEN-1:0];
                    idx_d   = '0;
                    state_d = (vl_clamped == '0) ? StDone : StExec;
                end
            end
            StExec: begin
                for (int s = 0; s < NumSlices; s++) begin
                    if (idx_q == VL_W'(s * LANES)) begin
                        for (int l = 0; l < LANES; l++) begin
                            // Elements at or beyond vl are tail: left untouched.
                            if (VL_W'(s*LANES + l) < vl_q) begin
                                act = vm_q | vmask_q[s*LANES+l];
                                if (op_q == OpMerge) begin
                                    vd_d[(s*LANES+l)*ELEN +: ELEN] =
                                        (!vm_q && vmask_q[s*LANES+l]) ? lane_a[l] : lane_b[l];
                                end else if (op_q == OpRedsum) begin
                                    if (act) begin
                                        acc_d = acc_d + lane_b[l];
                                    end
                                end else if (act) begin
                                    vd_d[(s*LANES+l)*ELEN +: ELEN] = lane_res[l];
                                end
                            end
                        end
                    end
                end
                idx_d = idx_q + VL_W'(LANES);
                if (idx_d >= vl_q) begin
                    state_d = StDone;
                    if (op_q == OpRedsum) begin
                        vd_d[ELEN-1:0] = acc_d;
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            vl_q    <= '0;
            op_q    <= '0;
            vm_q    <= 1'b0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            vmask_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
            op_q    <= op_d;
            vm_q    <= vm_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            vd_q    <= vd_d;
            vmask_q <= vmask_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_valu_vec_seq.sv
// Directed self-checking bench for valu_vec_seq (LANES=4, ELEN=32, VLMAX=32).
module tb_valu_vec_seq;

    localparam int unsigned LANES = 4;
    localparam int unsigned ELEN  = 32;
    localparam int unsigned VLMAX = 32;
    localparam int unsigned VL_W  = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            op;
    logic                  vm;
    logic [VL_W-1:0]       vl;
    logic [VLMAX*ELEN-1:0] vs1;
    logic [VLMAX*ELEN-1:0] vs2;
    logic [VLMAX*ELEN-1:0] vd_old;
    logic [VLMAX-1:0]      vmask;
    logic                  out_valid;
    logic                  out_ready;
    logic [VLMAX*ELEN-1:0] vd;

    always #5 clk = ~clk;

    valu_vec_seq #(
        .LANES(LANES),
        .ELEN (ELEN),
        .VLMAX(VLMAX),
        .VL_W (VL_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .vm_i       (vm),
        .vl_i       (vl),
        .vs1_i      (vs1),
        .vs2_i      (vs2),
        .vd_old_i   (vd_old),
        .vmask_i    (vmask),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .vd_o       (vd)
    );

    int total = 0;
    int bad   = 0;

    logic [ELEN-1:0] a_e   [VLMAX];
    logic [ELEN-1:0] b_e   [VLMAX];
    logic [ELEN-1:0] old_e [VLMAX];
    logic [ELEN-1:0] exp_e [VLMAX];

    logic [4:0]  t_op  [22];
    logic [31:0] t_res [22];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [ELEN-1:0] vd_elem(input int i);
        return vd[i*ELEN +: ELEN];
    endfunction

    task automatic check_vd(input string name);
        for (int i = 0; i < VLMAX; i++) begin
            check_eq($sformatf("%s_e%0d", name, i), vd_elem(i), exp_e[i]);
        end
    endtask

    // Issue one op, check latency, optional hold with out_ready low, result, release.
    task automatic run_op(input string name, input logic [4:0] op_v, input logic vm_v,
                          input logic [VL_W-1:0] vl_v, input logic [VLMAX-1:0] mask_v,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        for (int i = 0; i < VLMAX; i++) begin
            vs1[i*ELEN +: ELEN]    = a_e[i];
            vs2[i*ELEN +: ELEN]    = b_e[i];
            vd_old[i*ELEN +: ELEN] = old_e[i];
        end
        op       = op_v;
        vm       = vm_v;
        vl       = vl_v;
        vmask    = mask_v;
        in_valid = 1'b1;
        check_eq({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        // Inputs after accept must not matter.
        in_valid = 1'b0;
        vs1      = '1;
        vs2      = '1;
        vd_old   = '1;
        op       = 5'd1;
        vl       = '1;
        vm       = ~vm_v;
        vmask    = ~mask_v;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({name, "_lat"}, 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            in_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            check_eq($sformatf("%s_hold%0d_ov", name, h), 32'(out_valid), 32'd1);
            check_eq($sformatf("%s_hold%0d_rdy", name, h), 32'(in_ready), 32'd0);
            check_eq($sformatf("%s_hold%0d_e0", name, h), vd_elem(0), exp_e[0]);
            @(posedge clk);
            #1;
        end
        check_vd(name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq({name, "_ov_clr"}, 32'(out_valid), 32'd0);
        check_eq({name, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        t_op[0]  = 5'd0;  t_res[0]  = 32'hF000_0014;
        t_op[1]  = 5'd1;  t_res[1]  = 32'hF000_000C;
        t_op[2]  = 5'd2;  t_res[2]  = 32'h0FFF_FFF4;
        t_op[3]  = 5'd3;  t_res[3]  = 32'h0000_0000;
        t_op[4]  = 5'd4;  t_res[4]  = 32'hF000_0014;
        t_op[5]  = 5'd5;  t_res[5]  = 32'hF000_0014;
        t_op[6]  = 5'd6;  t_res[6]  = 32'h0000_0100;
        t_op[7]  = 5'd7;  t_res[7]  = 32'h0F00_0001;
        t_op[8]  = 5'd8;  t_res[8]  = 32'hFF00_0001;
        t_op[9]  = 5'd9;  t_res[9]  = 32'd0;
        t_op[10] = 5'd10; t_res[10] = 32'd1;
        t_op[11] = 5'd11; t_res[11] = 32'd0;
        t_op[12] = 5'd12; t_res[12] = 32'd1;
        t_op[13] = 5'd13; t_res[13] = 32'd0;
        t_op[14] = 5'd14; t_res[14] = 32'd1;
        t_op[15] = 5'd15; t_res[15] = 32'd1;
        t_op[16] = 5'd16; t_res[16] = 32'd0;
        t_op[17] = 5'd17; t_res[17] = 32'h0000_0004;
        t_op[18] = 5'd18; t_res[18] = 32'hF000_0010;
        t_op[19] = 5'd19; t_res[19] = 32'hF000_0010;
        t_op[20] = 5'd20; t_res[20] = 32'h0000_0004;
        t_op[21] = 5'd31; t_res[21] = 32'd0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        vm        = 1'b1;
        vl        = '0;
        vs1       = '0;
        vs2       = '0;
        vd_old    = '1;
        vmask     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ov", 32'(out_valid), 32'd0);
        check_eq("rst_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < VLMAX; i++) exp_e[i] = '0;
        check_vd("rst_vd");
        @(negedge clk);
        rst_n = 1'b1;

        // VADD vl=8, unmasked.
        for (int i = 0; i < VLMAX; i++) begin
            a_e[i]   = 32'(i);
            b_e[i]   = 32'd10;
            old_e[i] = 32'hA000_0000 | 32'(i);
            exp_e[i] = (i < 8) ? 32'(i + 10) : old_e[i];
        end
        run_op("vadd", 5'd0, 1'b1, 6'd8, '0, 3, 0);

        // VSUB vl=5, masked by 0x15.
        for (int i = 0; i < VLMAX; i++) begin
            a_e[i]   = 32'd100;
            b_e[i]   = 32'd1;
            old_e[i] = 32'hDEAD;
            exp_e[i] = 32'hDEAD;
        end
        exp_e[0] = 32'd99;
        exp_e[2] = 32'd99;
        exp_e[4] = 32'd99;
        run_op("vsub", 5'd1, 1'b0, 6'd5, 32'h0000_0015, 3, 0);

        // VMERGE masked, then vmv form.
        for (int i = 0; i < VLMAX; i++) begin
            a_e[i]   = 32'hAAAA_AAAA;
            b_e[i]   = 32'hBBBB_BBBB;
            old_e[i] = 32'hDEAD;
            exp_e[i] = 32'hDEAD;
        end
        exp_e[0] = 32'hAAAA_AAAA;
        exp_e[1] = 32'hBBBB_BBBB;
        exp_e[2] = 32'hAAAA_AAAA;
        exp_e[3] = 32'hBBBB_BBBB;
        run_op("vmerge", 5'd21, 1'b0, 6'd4, 32'h0000_0005, 2, 0);
        exp_e[0] = 32'hBBBB_BBBB;
        exp_e[2] = 32'hBBBB_BBBB;
        run_op("vmv", 5'd21, 1'b1, 6'd4, 32'h0000_0005, 2, 0);

        // VREDSUM vl=6, mask 111011: 1 + 1+2+4+5+6 = 19.
        for (int i = 0; i < VLMAX; i++) begin
            a_e[i]   = 32'(100 + i);
            b_e[i]   = 32'(i + 1);
            old_e[i] = 32'h5000 + 32'(i);
            exp_e[i] = old_e[i];
        end
        a_e[0]   = 32'd1;
        exp_e[0] = 32'd19;
        run_op("vredsum", 5'd22, 1'b0, 6'd6, 32'h0000_003B, 3, 0);

        // VREDSUM with vl=0 leaves vd_old.
        exp_e[0] = old_e[0];
        run_op("vredsum0", 5'd22, 1'b1, 6'd0, '0, 1, 0);

        // vl=0 add.
        run_op("vl0", 5'd0, 1'b1, 6'd0, '0, 1, 0);

        // vl=40 clamps to 32; out_ready held low for 5 cycles.
        for (int i = 0; i < VLMAX; i++) begin
            a_e[i]   = 32'(i);
            b_e[i]   = 32'(2 * i);
            exp_e[i] = 32'(3 * i);
        end
        exp_e[0] = 32'd0;
        run_op("clamp", 5'd0, 1'b1, 6'd40, '0, 9, 5);

        // Undefined op: active -> 0, inactive/tail undisturbed.
        for (int i = 0; i < VLMAX; i++) begin
            a_e[i]   = 32'h1234;
            b_e[i]   = 32'h5678;
            old_e[i] = 32'hCAFE_0000 | 32'(i);
            exp_e[i] = old_e[i];
        end
        exp_e[0] = 32'd0;
        run_op("undef", 5'd25, 1'b0, 6'd2, 32'h0000_0001, 2, 0);

        // Scalar op table, vl=1.
        for (int k = 0; k < 22; k++) begin
            for (int i = 0; i < VLMAX; i++) begin
                a_e[i]   = 32'hF000_0010;
                b_e[i]   = 32'h0000_0004;
                old_e[i] = 32'h7777_0000 | 32'(i);
                exp_e[i] = old_e[i];
            end
            exp_e[0] = t_res[k];
            run_op($sformatf("op%0d", t_op[k]), t_op[k], 1'b1, 6'd1, '0, 2, 0);
        end

        // Reset during EXEC discards the operation.
        @(negedge clk);
        for (int i = 0; i < VLMAX; i++) begin
            vs1[i*ELEN +: ELEN]    = 32'(i);
            vs2[i*ELEN +: ELEN]    = 32'd1;
            vd_old[i*ELEN +: ELEN] = 32'hFFFF_0000;
        end
        op       = 5'd0;
        vm       = 1'b1;
        vl       = 6'd32;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("rexec_rdy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rexec_ov", 32'(out_valid), 32'd0);
        check_eq("rexec_rdy1", 32'(in_ready), 32'd1);
        for (int i = 0; i < VLMAX; i++) exp_e[i] = '0;
        check_vd("rexec_vd");
        repeat (12) @(posedge clk);
        #1;
        check_eq("rexec_ov_late", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
